// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned NIBBLE_W = 4;

endpackage

// File: rtl/nibble_add_seq_fa4.sv
// 4-bit ripple-carry adder slice, the datapath shared by every nibble step.
module fa4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  // Ripple the carry through four full-adder cells.
  always_comb begin
    logic carry;
    S     = '0;
    carry = Cin;
    for (int i = 0; i < 4; i++) begin
      S[i]  = A[i] ^ B[i] ^ carry;
      carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    Cout = carry;
  end

endmodule

// File: rtl/nibble_add_seq.sv
// Nibble-serial add/subtract sequencer: one fa4 slice is reused once per
// clock, LSB nibble first, with the carry held in a register between steps.
module nibble_add_seq
  import nibble_add_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NIB  = WIDTH / NIBBLE_W;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned MSB  = WIDTH - 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_add_seq: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q;
  logic            carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] beff_q;  // b already inverted for subtract
  logic [WIDTH-1:0] sum_q;
  logic            cout_q;
  logic            ovf_q;

  logic [NIBBLE_W-1:0] slice_a, slice_b, slice_s;
  logic                slice_c;
  logic                last_step;

  assign slice_a   = a_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
  assign slice_b   = beff_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
  assign last_step = (idx_q == LAST_IDX);

  fa4 u_fa4 (
    .A    (slice_a),
    .B    (slice_b),
    .Cin  (carry_q),
    .S    (slice_s),
    .Cout (slice_c)
  );

  // Next-state logic for the IDLE -> RUN -> DONE controller.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture, per-nibble accumulation and final flag capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      beff_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            beff_q  <= sub ? ~b : b;
            // Subtract is A + ~B + 1, so the carry-in becomes the +1.
            carry_q <= sub ? 1'b1 : cin;
            sum_q   <= '0;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W] <= slice_s;
          carry_q <= slice_c;
          if (last_step) begin
            cout_q <= slice_c;
            // Sign of the top slice result is the final result sign.
            ovf_q  <= (a_q[MSB] == beff_q[MSB]) && (slice_s[NIBBLE_W-1] != a_q[MSB]);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake and status outputs decode from the state register only.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
